uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter CLKS, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 9600, serial bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; the block uses one clock, and all logic is on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port PC_Uart_rxd  input  1  asynchronous serial line from the PC; idles high.
REQ-006 Port rx_data  output  8  last correctly received byte.
REQ-007 Port rx_valid  output  1  one-cycle pulse; rx_data is updated on the same cycle.
REQ-008 Port frame_err  output  1  one-cycle pulse when a byte is rejected.
REQ-009 Port led_pattern  output  8  value from the last accepted command.
REQ-010 Port cmd_valid  output  1  one-cycle pulse; led_pattern is updated on the same cycle.
REQ-011 Port cmd_err  output  1  one-cycle pulse when a command is malformed or aborted.

Function
REQ-012 PC_Uart_rxd shall pass through a 2-FF synchronizer before any other use.
REQ-013 Oversample tick period shall be DIV = CLKS/(BAUDRATE*16) cycles, with integer truncation (651 at the default parameters).
REQ-014 Byte receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: a synchronized high-to-low transition shall clear the divider and the sample counter, then go to START.
REQ-016 START: sample the line at tick 8.
- Low: go to DATA.
- High: treat as a glitch, return to IDLE, no pulse.
REQ-017 DATA: sample 8 bits every 16 ticks after the start mid-sample, LSB first, into a shift register.
REQ-018 STOP: sample the line 16 ticks after the last data bit.
- High: pulse rx_valid, load rx_data, go to IDLE.
- Low: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until the synchronized line is high, then go to IDLE.
REQ-020 rx_valid and frame_err shall never be asserted on the same cycle.
REQ-021 Parser FSM states: P_IDLE, P_HI, P_LO, P_END; it advances only on rx_valid or frame_err.
REQ-022 P_IDLE transitions:
- 'L' (0x4C) or 'l' (0x6C): go to P_HI.
- CR (0x0D), LF (0x0A), space (0x20): ignore, stay.
- Any other byte: pulse cmd_err, stay.
REQ-023 P_HI and P_LO accept hex digits 0-9, A-F, a-f.
- P_HI: store the high nibble, go to P_LO.
- P_LO: store the low nibble, go to P_END.
- Any non-hex byte: pulse cmd_err, go to P_IDLE.
REQ-024 P_END transitions:
- CR: load led_pattern with the assembled byte and pulse cmd_valid, one cycle after the CR's rx_valid; go to P_IDLE.
- Any other byte: pulse cmd_err, go to P_IDLE, leave led_pattern unchanged.
REQ-025 A frame_err in any parser state other than P_IDLE shall pulse cmd_err and go to P_IDLE; in P_IDLE, frame_err shall be ignored by the parser.
REQ-026 led_pattern shall change only on a cmd_valid cycle.

Reset
REQ-027 When rst is high at a clock edge, the following shall be forced:
- Both FSMs to IDLE/P_IDLE.
- Divider, sample counter, shift register and nibble registers to 0.
- Synchronizer flops to 1.
- rx_data = 0x00, led_pattern = 0x00, all pulse outputs = 0.
REQ-028 Reset asserted mid-byte or mid-command shall discard the partial byte or command with no pulse.

Configuration
REQ-029 Macro UART_RX_PARITY_EN. When defined:
- Frame format is 8E1.
- The parity bit is sampled 16 ticks after bit 7, and STOP follows 16 ticks later.
- A parity mismatch with a valid stop bit shall pulse frame_err and go to IDLE.
REQ-030 When UART_RX_PARITY_EN is undefined, the frame format is 8N1 and no parity logic is present.

Verification
REQ-031 Command: 'L','A','5',CR at 9600 baud -> four rx_valid pulses, then cmd_valid once, led_pattern = 0xA5.
REQ-032 Glitch: 200-cycle low pulse on PC_Uart_rxd while idle -> no rx_valid, no frame_err.
REQ-033 Framing: byte 0x55 with a low stop bit -> frame_err once, no rx_valid, rx_data unchanged; the next good byte is received correctly.
REQ-034 Bad digit: 'L','G' -> cmd_err on 'G', led_pattern unchanged; then 'l','f','F',CR -> led_pattern = 0xFF.
REQ-035 Reset: rst pulsed during bit 4 of a byte -> all outputs 0, no pulses; a following 'L','0','1',CR -> led_pattern = 0x01.
REQ-036 Parity (UART_RX_PARITY_EN defined): 0x07 with parity bit 0 -> frame_err; 0x07 with parity bit 1 -> rx_valid, rx_data = 0x07.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART byte receiver (16x oversampling) feeding a small command
// parser that accepts "L<hi><lo><CR>" and latches the hex byte onto led_pattern.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   PC_Uart_rxd  asynchronous serial input, idles high
//   rx_data      last correctly received byte
//   rx_valid     one-cycle pulse, rx_data updated on the same cycle
//   frame_err    one-cycle pulse when a byte is rejected
//   led_pattern  byte from the last accepted command
//   cmd_valid    one-cycle pulse, led_pattern updated on the same cycle
//   cmd_err      one-cycle pulse on a malformed or aborted command
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames (default 8N1).

module uart_cmd_rx #(
    parameter int unsigned CLKS     = 100000000,
    parameter int unsigned BAUDRATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PC_Uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] led_pattern,
    output logic       cmd_valid,
    output logic       cmd_err
);

    localparam int unsigned DIV   = CLKS / (BAUDRATE * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_L_UC  = 8'h4C;
    localparam logic [7:0] CH_L_LC  = 8'h6C;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_HIGH
    } rx_state_t;
`endif

    typedef enum logic [1:0] {
        P_IDLE, P_HI, P_LO, P_END
    } p_state_t;

    rx_state_t         state;
    p_state_t          pstate;

    logic              sync1;
    logic              sync2;
    logic              line_prev;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [3:0]        tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [3:0]        hi_nib;
    logic [3:0]        lo_nib;
    logic [4:0]        hex;
`ifdef UART_RX_PARITY_EN
    logic              par_err;
`endif

    // Returns {is_hex, nibble} for an ASCII hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, 4'(b - 8'h30)};
        else if (b >= 8'h41 && b <= 8'h46)
            r = {1'b1, 4'(b - 8'h37)};
        else if (b >= 8'h61 && b <= 8'h66)
            r = {1'b1, 4'(b - 8'h57)};
        return r;
    endfunction

    assign tick = (div_cnt == DIV_W'(DIV - 1));
    assign hex  = hex_decode(rx_data);

    // Byte receiver: synchronizer, oversample divider and frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            div_cnt   <= '0;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            sync1     <= PC_Uart_rxd;
            sync2     <= sync1;
            line_prev <= sync2;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            // Divider held cleared while idle so a new frame starts phase-aligned.
            if (state == IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= 4'd0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick)
                    tick_cnt <= tick_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (!sync2 && line_prev)
                        state <= START;
                end
                START: begin
                    // Mid-start sample; counter restarts so later samples land every 16 ticks.
                    if (tick && tick_cnt == 4'd7) begin
                        tick_cnt <= 4'd0;
                        if (!sync2) begin
                            bit_cnt <= 3'd0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick && tick_cnt == 4'd15) begin
                        shift   <= {sync2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    // Even parity: data bits plus parity bit hold an even count of ones.
                    if (tick && tick_cnt == 4'd15) begin
                        par_err <= (sync2 != ^shift);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick && tick_cnt == 4'd15) begin
                        if (sync2) begin
`ifdef UART_RX_PARITY_EN
                            if (par_err) begin
                                frame_err <= 1'b1;
                            end else begin
                                rx_valid <= 1'b1;
                                rx_data  <= shift;
                            end
`else
                            rx_valid <= 1'b1;
                            rx_data  <= shift;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (sync2)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command parser: steps only on received or rejected bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate      <= P_IDLE;
            hi_nib      <= 4'd0;
            lo_nib      <= 4'd0;
            led_pattern <= 8'h00;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            if (frame_err) begin
                if (pstate != P_IDLE) begin
                    cmd_err <= 1'b1;
                    pstate  <= P_IDLE;
                end
            end else if (rx_valid) begin
                case (pstate)
                    P_IDLE: begin
                        if (rx_data == CH_L_UC || rx_data == CH_L_LC)
                            pstate <= P_HI;
                        else if (rx_data != CH_CR && rx_data != CH_LF &&
                                 rx_data != CH_SPACE)
                            cmd_err <= 1'b1;
                    end
                    P_HI: begin
                        if (hex[4]) begin
                            hi_nib <= hex[3:0];
                            pstate <= P_LO;
                        end else begin
                            cmd_err <= 1'b1;
                            pstate  <= P_IDLE;
                        end
                    end
                    P_LO: begin
                        if (hex[4]) begin
                            lo_nib <= hex[3:0];
                            pstate <= P_END;
                        end else begin
                            cmd_err <= 1'b1;
                            pstate  <= P_IDLE;
                        end
                    end
                    P_END: begin
                        if (rx_data == CH_CR) begin
                            led_pattern <= {hi_nib, lo_nib};
                            cmd_valid   <= 1'b1;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                        pstate <= P_IDLE;
                    end
                    default: pstate <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: table of serial bytes with expected pulse counts and
// register values, plus hand-written glitch, reset and parity sequences.
// Runs at CLKS=1290, BAUDRATE=10 so DIV truncates to 8 (128 clocks per bit).

module tb_uart_cmd_rx;

    localparam int BIT = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] led_pattern;
    logic       cmd_valid;
    logic       cmd_err;

    int checks   = 0;
    int failures = 0;

    int n_rxv = 0, n_fe = 0, n_cv = 0, n_ce = 0, n_both = 0, n_led_bad = 0;
    int cyc = 0, last_rxv_cyc = 0, last_cv_cyc = 0;
    logic [7:0] led_prev = 8'h00;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         rxv;
        int         fe;
        logic [7:0] data;
        int         cv;
        int         ce;
        logic [7:0] led;
    } vec_t;

    vec_t vt[21];

    uart_cmd_rx #(.CLKS(1290), .BAUDRATE(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .PC_Uart_rxd (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .led_pattern (led_pattern),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rx_valid) begin n_rxv++; last_rxv_cyc = cyc; end
        if (frame_err) n_fe++;
        if (cmd_valid) begin n_cv++; last_cv_cyc = cyc; end
        if (cmd_err) n_ce++;
        if (rx_valid && frame_err) n_both++;
        if (led_pattern != led_prev && !cmd_valid && !rst) n_led_bad++;
        led_prev = led_pattern;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, [parity], stop, then one idle bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        @(negedge clk) rxd = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_bits(1);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        wait_bits(1);
`else
        if (par) rxd = 1'b1;
`endif
        rxd = stop;
        wait_bits(1);
        rxd = 1'b1;
        wait_bits(1);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    initial begin
        int r0, f0, c0, e0;

        vt[0]  = '{8'h4C, 1'b1, 1, 0, 8'h4C, 0, 0, 8'h00};
        vt[1]  = '{8'h41, 1'b1, 1, 0, 8'h41, 0, 0, 8'h00};
        vt[2]  = '{8'h35, 1'b1, 1, 0, 8'h35, 0, 0, 8'h00};
        vt[3]  = '{8'h0D, 1'b1, 1, 0, 8'h0D, 1, 0, 8'hA5};
        vt[4]  = '{8'h55, 1'b0, 0, 1, 8'h0D, 0, 0, 8'hA5};
        vt[5]  = '{8'h4C, 1'b1, 1, 0, 8'h4C, 0, 0, 8'hA5};
        vt[6]  = '{8'h47, 1'b1, 1, 0, 8'h47, 0, 1, 8'hA5};
        vt[7]  = '{8'h6C, 1'b1, 1, 0, 8'h6C, 0, 0, 8'hA5};
        vt[8]  = '{8'h66, 1'b1, 1, 0, 8'h66, 0, 0, 8'hA5};
        vt[9]  = '{8'h46, 1'b1, 1, 0, 8'h46, 0, 0, 8'hA5};
        vt[10] = '{8'h0D, 1'b1, 1, 0, 8'h0D, 1, 0, 8'hFF};
        vt[11] = '{8'h20, 1'b1, 1, 0, 8'h20, 0, 0, 8'hFF};
        vt[12] = '{8'h0A, 1'b1, 1, 0, 8'h0A, 0, 0, 8'hFF};
        vt[13] = '{8'h58, 1'b1, 1, 0, 8'h58, 0, 1, 8'hFF};
        vt[14] = '{8'h4C, 1'b1, 1, 0, 8'h4C, 0, 0, 8'hFF};
        vt[15] = '{8'h31, 1'b1, 1, 0, 8'h31, 0, 0, 8'hFF};
        vt[16] = '{8'h55, 1'b0, 0, 1, 8'h31, 0, 1, 8'hFF};
        vt[17] = '{8'h4C, 1'b1, 1, 0, 8'h4C, 0, 0, 8'hFF};
        vt[18] = '{8'h32, 1'b1, 1, 0, 8'h32, 0, 0, 8'hFF};
        vt[19] = '{8'h33, 1'b1, 1, 0, 8'h33, 0, 0, 8'hFF};
        vt[20] = '{8'h34, 1'b1, 1, 0, 8'h34, 0, 1, 8'hFF};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset led_pattern", led_pattern, 8'h00);
        check("reset cmd_valid", cmd_valid, 1'b0);
        check("reset cmd_err", cmd_err, 1'b0);
        wait_bits(1);

        for (int i = 0; i < 21; i++) begin
            r0 = n_rxv; f0 = n_fe; c0 = n_cv; e0 = n_ce;
            send_frame(vt[i].b, ^vt[i].b, vt[i].stop);
            check($sformatf("v%0d rx_valid count", i), n_rxv - r0, vt[i].rxv);
            check($sformatf("v%0d frame_err count", i), n_fe - f0, vt[i].fe);
            check($sformatf("v%0d rx_data", i), rx_data, vt[i].data);
            check($sformatf("v%0d cmd_valid count", i), n_cv - c0, vt[i].cv);
            check($sformatf("v%0d cmd_err count", i), n_ce - e0, vt[i].ce);
            check($sformatf("v%0d led_pattern", i), led_pattern, vt[i].led);
            if (vt[i].cv == 1)
                check($sformatf("v%0d cmd_valid latency", i), last_cv_cyc - last_rxv_cyc, 1);
        end

        // Short low glitch on an idle line must not start a frame.
        r0 = n_rxv; f0 = n_fe;
        @(negedge clk) rxd = 1'b0;
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        wait_bits(3);
        check("glitch rx_valid count", n_rxv - r0, 0);
        check("glitch frame_err count", n_fe - f0, 0);
        check("glitch rx_data", rx_data, 8'h34);

        // Reset in the middle of bit 4 of a byte, with a command half-entered.
        send_good(8'h4C);
        @(negedge clk) rxd = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rxd = i[1];
            wait_bits(1);
        end
        rxd = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        r0 = n_rxv; f0 = n_fe; c0 = n_cv; e0 = n_ce;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midbyte reset rx_data", rx_data, 8'h00);
        check("midbyte reset led_pattern", led_pattern, 8'h00);
        wait_bits(8);
        check("midbyte reset rx_valid count", n_rxv - r0, 0);
        check("midbyte reset frame_err count", n_fe - f0, 0);
        check("midbyte reset cmd_valid count", n_cv - c0, 0);
        check("midbyte reset cmd_err count", n_ce - e0, 0);
        send_good(8'h4C);
        send_good(8'h30);
        send_good(8'h31);
        send_good(8'h0D);
        check("after reset cmd_valid count", n_cv - c0, 1);
        check("after reset cmd_err count", n_ce - e0, 0);
        check("after reset led_pattern", led_pattern, 8'h01);
        check("after reset rx_valid count", n_rxv - r0, 4);

`ifdef UART_RX_PARITY_EN
        r0 = n_rxv; f0 = n_fe;
        send_frame(8'h07, 1'b0, 1'b1);
        check("bad parity frame_err count", n_fe - f0, 1);
        check("bad parity rx_valid count", n_rxv - r0, 0);
        check("bad parity rx_data", rx_data, 8'h0D);
        send_frame(8'h07, 1'b1, 1'b1);
        check("good parity rx_valid count", n_rxv - r0, 1);
        check("good parity frame_err count", n_fe - f0, 1);
        check("good parity rx_data", rx_data, 8'h07);
`endif

        check("rx_valid with frame_err overlap", n_both, 0);
        check("led_pattern change without cmd_valid", n_led_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
